// File: rtl/riscv_loader_pkg.sv
// Shared types and defaults for the instruction-memory loader.
package riscv_loader_pkg;

   localparam int unsigned IMEM_DEPTH_DEFAULT = 64;

   typedef enum logic [2:0] {
      StIdle,
      StRecv,
      StWrite,
      StDone,
      StErr
   } loader_state_t;

endpackage

// File: rtl/word_packer.sv
// Assembles little-endian bytes into a 32-bit word and flags the fourth byte.
module word_packer (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        clear_i,
   input  logic        accept_i,
   input  logic [7:0]  byte_i,
   output logic [31:0] word_o,
   output logic        full_o
);

   logic [31:0] buf_q, buf_d;
   logic [1:0]  idx_q, idx_d;

   always_comb begin
      buf_d = buf_q;
      idx_d = idx_q;
      if (clear_i) begin
         buf_d = '0;
         idx_d = '0;
      end else if (accept_i) begin
         buf_d[{idx_q, 3'b000} +: 8] = byte_i;
         idx_d = idx_q + 2'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         buf_q <= '0;
         idx_q <= '0;
      end else begin
         buf_q <= buf_d;
         idx_q <= idx_d;
      end
   end

   assign word_o = buf_q;
   assign full_o = accept_i & (idx_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Streams a byte-wide program into instruction memory, holding the core in reset
// until the requested number of words has been written.
module imem_loader
   import riscv_loader_pkg::*;
#(
   parameter int unsigned IMEM_DEPTH = IMEM_DEPTH_DEFAULT,
   parameter int unsigned ADDR_W     = $clog2(IMEM_DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W:0]   word_count,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              core_reset,
   output logic              done,
   output logic              error
);

   localparam logic [ADDR_W:0] MAX_COUNT = (ADDR_W+1)'(IMEM_DEPTH);

   loader_state_t     state_q, state_d;
   logic [ADDR_W-1:0] word_idx_q, word_idx_d;
   logic [ADDR_W:0]   count_q, count_d;

   logic        pack_clear;
   logic        word_full;
   logic [31:0] word;
   logic        count_ok;
   logic        last_word;

   assign count_ok  = (word_count != '0) && (word_count <= MAX_COUNT);
   assign last_word = ({1'b0, word_idx_q} == (count_q - (ADDR_W+1)'(1)));

   word_packer u_packer (
      .clk_i    (clk),
      .reset_i  (reset),
      .clear_i  (pack_clear),
      .accept_i (byte_valid & byte_ready),
      .byte_i   (byte_data),
      .word_o   (word),
      .full_o   (word_full)
   );

   always_comb begin
      state_d    = state_q;
      word_idx_d = word_idx_q;
      count_d    = count_q;
      pack_clear = 1'b0;
      byte_ready = 1'b0;
      imem_we    = 1'b0;
      imem_addr  = '0;
      imem_wdata = '0;
      core_reset = 1'b1;
      done       = 1'b0;
      error      = 1'b0;

      case (state_q)
         StIdle, StDone: begin
            if (state_q == StDone) begin
               done       = 1'b1;
               core_reset = 1'b0;
            end
            // A restart from DONE behaves exactly like a fresh request from IDLE.
            if (start) begin
               if (count_ok) begin
                  count_d    = word_count;
                  word_idx_d = '0;
                  pack_clear = 1'b1;
                  state_d    = StRecv;
               end else begin
                  state_d = StErr;
               end
            end
         end
         StRecv: begin
            byte_ready = 1'b1;
            if (word_full) state_d = StWrite;
         end
         StWrite: begin
            imem_we    = 1'b1;
            imem_addr  = word_idx_q;
            imem_wdata = word;
            if (last_word) begin
               state_d = StDone;
            end else begin
               word_idx_d = word_idx_q + ADDR_W'(1);
               state_d    = StRecv;
            end
         end
         StErr: begin
            error = 1'b1;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         word_idx_q <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         word_idx_q <= word_idx_d;
         count_q    <= count_d;
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: count-validation table, directed corner
// sequences and randomized loads checked against a byte-stream reference model.
module tb_imem_loader;

   localparam int DEPTH = 64;
   localparam int AW    = 6;

   logic          clk;
   logic          reset;
   logic          start;
   logic [AW:0]   word_count;
   logic          byte_valid;
   logic [7:0]    byte_data;
   logic          byte_ready;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic          core_reset;
   logic          done;
   logic          error;

   imem_loader #(
      .IMEM_DEPTH (DEPTH)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .word_count (word_count),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .core_reset (core_reset),
      .done       (done),
      .error      (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc_n  = 0;

   logic [7:0]    prog[$];
   logic [AW-1:0] wr_addr[$];
   logic [31:0]   wr_data[$];

   typedef struct {
      int   cnt;
      logic exp_err;
      logic exp_ready;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Advance one clock; outputs are sampled on the falling edge and writes logged.
   task automatic cyc();
      @(negedge clk);
      cyc_n++;
      if (imem_we) begin
         wr_addr.push_back(imem_addr);
         wr_data.push_back(imem_wdata);
      end
   endtask

   task automatic chk_rst(input string tag);
      chk({tag, " byte_ready"}, byte_ready, 0);
      chk({tag, " imem_we"}, imem_we, 0);
      chk({tag, " imem_addr"}, imem_addr, 0);
      chk({tag, " imem_wdata"}, imem_wdata, 0);
      chk({tag, " core_reset"}, core_reset, 1);
      chk({tag, " done"}, done, 0);
      chk({tag, " error"}, error, 0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      start = 1'b0;
      byte_valid = 1'b0;
      cyc();
      cyc();
      reset = 1'b0;
      wr_addr.delete();
      wr_data.delete();
   endtask

   function automatic logic [31:0] exp_word(input int i);
      return {prog[4*i+3], prog[4*i+2], prog[4*i+1], prog[4*i]};
   endfunction

   task automatic fill_prog(input int words);
      prog.delete();
      for (int i = 0; i < 4 * words; i++) prog.push_back(8'($urandom_range(0, 255)));
   endtask

   // mode 0: back-to-back, 1: valid on alternate cycles, 2: random gaps.
   task automatic run_load(input int cnt, input int mode, input int pulse_at,
                           input int pulse_cnt, input string tag, output int lat);
      int   idx = 0;
      int   k = 0;
      int   c0;
      bit   ok = 0;
      logic rdy;
      logic v;
      wr_addr.delete();
      wr_data.delete();
      word_count = (AW+1)'(cnt);
      start = 1'b1;
      cyc();
      start = 1'b0;
      c0 = cyc_n;
      chk({tag, " start core_reset"}, core_reset, 1);
      chk({tag, " start byte_ready"}, byte_ready, 1);
      chk({tag, " start done"}, done, 0);
      while (k < 20 * cnt + 50) begin
         if (done) begin
            ok = 1;
            break;
         end
         v = (idx < prog.size()) &&
             ((mode == 0) || (mode == 1 && k % 2 == 0) ||
              (mode == 2 && $urandom_range(0, 3) != 0));
         byte_valid = v;
         byte_data  = v ? prog[idx] : 8'($urandom_range(0, 255));
         if (k == pulse_at) begin
            start = 1'b1;
            word_count = (AW+1)'(pulse_cnt);
         end
         rdy = byte_ready;
         cyc();
         start = 1'b0;
         if (v && rdy) idx++;
         k++;
      end
      byte_valid = 1'b0;
      lat = cyc_n - c0;
      chk({tag, " done reached"}, ok, 1);
      chk({tag, " done core_reset"}, core_reset, 0);
      chk({tag, " done error"}, error, 0);
      chk({tag, " write count"}, wr_addr.size(), cnt);
      for (int i = 0; i < cnt; i++) begin
         if (i < wr_addr.size()) begin
            chk({tag, $sformatf(" addr[%0d]", i)}, wr_addr[i], i);
            chk({tag, $sformatf(" data[%0d]", i)}, wr_data[i], exp_word(i));
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int cnt;
      int we_seen;

      reset = 1'b1;
      start = 1'b0;
      word_count = '0;
      byte_valid = 1'b0;
      byte_data = '0;
      cyc();
      cyc();
      chk_rst("reset held");
      reset = 1'b0;
      cyc();
      chk_rst("idle after reset");

      // Count validation: outputs one cycle after start.
      vecs[0] = '{cnt: 0,   exp_err: 1'b1, exp_ready: 1'b0};
      vecs[1] = '{cnt: 1,   exp_err: 1'b0, exp_ready: 1'b1};
      vecs[2] = '{cnt: 64,  exp_err: 1'b0, exp_ready: 1'b1};
      vecs[3] = '{cnt: 65,  exp_err: 1'b1, exp_ready: 1'b0};
      vecs[4] = '{cnt: 127, exp_err: 1'b1, exp_ready: 1'b0};
      vecs[5] = '{cnt: 7,   exp_err: 1'b0, exp_ready: 1'b1};
      for (int i = 0; i < 6; i++) begin
         do_reset();
         word_count = (AW+1)'(vecs[i].cnt);
         start = 1'b1;
         cyc();
         start = 1'b0;
         chk($sformatf("tbl%0d error", i), error, vecs[i].exp_err);
         chk($sformatf("tbl%0d byte_ready", i), byte_ready, vecs[i].exp_ready);
         chk($sformatf("tbl%0d core_reset", i), core_reset, 1);
         chk($sformatf("tbl%0d imem_we", i), imem_we, 0);
      end

      // Two-word program sent back-to-back.
      do_reset();
      prog = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
      run_load(2, 0, -1, 0, "basic", lat);
      chk("basic latency", lat, 10);
      if (wr_data.size() == 2) begin
         chk("basic word0 const", wr_data[0], 32'h0050_0013);
         chk("basic word1 const", wr_data[1], 32'h0010_0093);
      end
      cyc();
      chk("basic done held", done, 1);
      chk("basic core released", core_reset, 0);

      // Restart from DONE reloads from address 0.
      fill_prog(1);
      run_load(1, 0, -1, 0, "reload", lat);
      chk("reload latency", lat, 5);

      // start pulsed while receiving is ignored.
      do_reset();
      fill_prog(1);
      run_load(1, 0, 1, 3, "recv_start", lat);
      chk("recv_start latency", lat, 5);

      // byte_valid toggling 1,0,1,0.
      do_reset();
      prog = '{8'h13, 8'h00, 8'h50, 8'h00};
      run_load(1, 1, -1, 0, "toggle", lat);
      chk("toggle latency", lat, 8);

      // Zero count goes to ERR; later start is ignored there.
      do_reset();
      word_count = '0;
      start = 1'b1;
      cyc();
      word_count = (AW+1)'(1);
      chk("err error", error, 1);
      chk("err core_reset", core_reset, 1);
      chk("err done", done, 0);
      cyc();
      start = 1'b0;
      for (int i = 0; i < 6; i++) cyc();
      chk("err sticky", error, 1);
      chk("err byte_ready", byte_ready, 0);
      chk("err no write", wr_addr.size(), 0);

      // Full depth: last write at 63, no wrap.
      do_reset();
      fill_prog(DEPTH);
      run_load(DEPTH, 0, -1, 0, "full", lat);
      chk("full latency", lat, 5 * DEPTH);
      if (wr_addr.size() > 0) chk("full last addr", wr_addr[wr_addr.size()-1], 63);

      // Reset after two bytes of word 0 discards the partial word.
      do_reset();
      word_count = (AW+1)'(2);
      start = 1'b1;
      cyc();
      start = 1'b0;
      byte_valid = 1'b1;
      byte_data = 8'hAA;
      cyc();
      byte_data = 8'h55;
      cyc();
      byte_valid = 1'b0;
      reset = 1'b1;
      cyc();
      chk_rst("mid reset");
      reset = 1'b0;
      we_seen = 0;
      for (int i = 0; i < 4; i++) cyc();
      we_seen = wr_addr.size();
      chk("mid reset no write", we_seen, 0);
      chk_rst("mid reset idle");

      // Randomized loads against the byte-stream model.
      do_reset();
      for (int r = 0; r < 6; r++) begin
         cnt = $urandom_range(1, 8);
         fill_prog(cnt);
         run_load(cnt, 2, -1, 0, $sformatf("rand%0d", r), lat);
         chk($sformatf("rand%0d latency floor", r), lat >= 5 * cnt, 1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
